seg7_mux_driver: RTL and testbench
==================================

// Module: seg7_mux_driver
// PURPOSE
//  Downstream stage of the binary-to-BCD converter. Takes the tens and units digits (L1, L0).
//  Drives a 2-digit, common-segment 7-segment display by time multiplexing.
//  Digits are captured on LOAD and applied only at a frame boundary, so the display never tears.
//  Adds inter-digit blanking gaps against ghosting, leading-zero blanking and a dash for invalid BCD.
// PARAMETERS
//  REFRESH_DIV    50000  clock cycles each digit is lit per frame (>=2)
//  GAP_CYC        4      all-off cycles after each digit slot (0 = no gap states)
//  ACTIVE_LOW     1      1: SEG and AN are active-low at the pins; 0: active-high
//  BLANK_LEADING  1      1: tens digit dark when it is 0
// PORTS
//  CLK         in   1  system clock, rising edge
//  RST_N       in   1  asynchronous active-low reset
//  L1          in   4  tens BCD digit
//  L0          in   4  units BCD digit
//  LOAD        in   1  capture L1/L0 on this rising edge
//  SEG         out  7  {g,f,e,d,c,b,a} segment drive, registered
//  AN          out  2  digit enables: AN[0]=units, AN[1]=tens, registered
//  FRAME_TICK  out  1  one-cycle pulse, registered, on each frame boundary
// BEHAVIOUR
//  - Reset (async, immediate):
//    - State S_D0, slot counter 0, active digits 0/0, pending register cleared, pend flag 0.
//    - SEG and AN are all-off at the pin polarity: 7'h7F/2'b11 if ACTIVE_LOW, else 0. FRAME_TICK 0.
//  - FSM: S_D0 (units) -> S_G0 -> S_D1 (tens) -> S_G1 -> S_D0.
//    - Each S_Dx lasts REFRESH_DIV cycles. Each S_Gx lasts GAP_CYC cycles and is skipped when GAP_CYC=0.
//    - Frame = 2*REFRESH_DIV + 2*GAP_CYC cycles.
//  - Counter: width $clog2(REFRESH_DIV). Clears on every state change; no free-running wrap.
//  - Frame boundary: the transition S_G1 (or S_D1 when GAP_CYC=0) -> S_D0.
//    - FRAME_TICK is high in the first S_D0 output cycle.
//    - The first S_D0 entry after reset release is not a boundary and gives no FRAME_TICK.
//  - Shadowing:
//    - LOAD=1 writes L1/L0 to the pending register and sets pend. A later LOAD overwrites (last wins).
//    - At a boundary with pend=1, pending -> active digits and pend clears.
//    - LOAD on the boundary cycle bypasses: the new L1/L0 go straight to active for that frame, and pend ends 0.
//  - Outputs are registered from the next state and counter: one cycle of latency from state to pins.
//  - Decode, active-high patterns before ACTIVE_LOW inversion:
//    - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//    - Values 10..15 show a dash, 40.
//  - S_D0: AN[0] on, SEG=decode(L0 active).
//  - S_D1: AN[1] on, SEG=decode(L1 active).
//    - If BLANK_LEADING and tens=0: AN off and SEG off for the whole slot. Slot timing is unchanged.
//  - S_Gx: AN off, SEG off.
//  - Invariant: AN never has both digits on. SEG is never non-off while AN is all-off.
//  - Reset asserted mid-frame: outputs go off without waiting for a clock edge; pending data is lost.
//    - After release, the display restarts at S_D0 showing 00 (tens blanked if BLANK_LEADING).
// STRUCTURE
//  - Package seg7_pkg:
//    - state enum {S_D0, S_G0, S_D1, S_G1}.
//    - Segment constants SEG_BLANK=7'h00 and SEG_DASH=7'h40, plus the 0..9 table.
//    - Function bcd_to_seg(4-bit) -> 7-bit active-high.
//  - One sub-module, seg7_decode: combinational BCD -> pattern wrapper around bcd_to_seg, instantiated once on the muxed digit.
//  - Top holds the FSM, counter, shadow/pending registers and output registers.
// TESTING  (REFRESH_DIV=8, GAP_CYC=2, ACTIVE_LOW=0, BLANK_LEADING=1)
//  1. Reset then LOAD L1=4 L0=2 -> after the next FRAME_TICK:
//     AN=01 SEG=5B x8 cycles, then 00/00 x2, then AN=10 SEG=66 x8, then 00/00 x2. Period 20 cycles.
//  2. LOAD 0/7 -> units slot SEG=07. Tens slot AN=00 SEG=00 for 8 cycles, and the period stays 20.
//  3. LOAD L1=4'hA L0=4'hC -> both slots SEG=40. Digit decode checked for all 0..9 in both slots.
//  4. LOAD 1/2 mid-frame, then LOAD 3/4 before the boundary -> 12 never appears, the next frame shows 34.
//     No mixed frame at any point.
//  5. LOAD 5/6 exactly on the boundary cycle -> 56 shown in that same frame (bypass), and pend reads 0.
//  6. Assert RST_N low in the middle of S_D1 between clock edges -> SEG/AN=0 immediately.
//     After release, units SEG=3F, tens dark, and no FRAME_TICK until the first real boundary.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, segment constants and the BCD-to-segment lookup for the
// two-digit multiplexed 7-segment display driver.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_D0 = 2'd0,
      S_G0 = 2'd1,
      S_D1 = 2'd2,
      S_G1 = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   // Active-high {g,f,e,d,c,b,a}; entry 9 sits in the top slice.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      if (d > 4'd9) return SEG_DASH;
      return SEG_TABLE[d];
   endfunction

endpackage

// File: rtl/seg7_mux_driver_if.sv
// Digit load side and pin side of the multiplexed 7-segment driver.
interface seg7_mux_driver_if;
   logic [3:0] l1;
   logic [3:0] l0;
   logic       load;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_tick;

   modport master (
      output l1, l0, load,
      input  seg, an, frame_tick
   );

   modport slave (
      input  l1, l0, load,
      output seg, an, frame_tick
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high segment pattern (dash for 10..15).
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit time-multiplexed 7-segment driver with frame-synchronous digit
// update, blanking gaps between digits, leading-zero blanking and dash for bad BCD.
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV   = 50000,
   parameter int GAP_CYC       = 4,
   parameter int ACTIVE_LOW    = 1,
   parameter int BLANK_LEADING = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_mux_driver_if.slave  bus
);

   localparam int          CW       = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
   localparam bit          HAS_GAP  = (GAP_CYC > 0);
   localparam logic [6:0]  SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0]  AN_OFF   = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic            boundary;
   logic [3:0]      act_l1_q, act_l0_q, act_l1_n, act_l0_n;
   logic [3:0]      pend_l1_q, pend_l0_q;
   logic            pend_q;
   logic [3:0]      digit;
   logic [6:0]      dec_seg;
   logic [6:0]      seg_n;
   logic [1:0]      an_n;
   logic [6:0]      seg_q;
   logic [1:0]      an_q;
   logic            tick_q;

   // Slot sequencer; the counter restarts on every state change.
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q + 1'b1;
      boundary = 1'b0;
      case (state_q)
         S_D0: if (cnt_q == DIV_LAST) begin
            state_n = HAS_GAP ? S_G0 : S_D1;
            cnt_n   = '0;
         end
         S_G0: if (cnt_q == GAP_LAST) begin
            state_n = S_D1;
            cnt_n   = '0;
         end
         S_D1: if (cnt_q == DIV_LAST) begin
            cnt_n = '0;
            if (HAS_GAP) begin
               state_n = S_G1;
            end else begin
               state_n  = S_D0;
               boundary = 1'b1;
            end
         end
         S_G1: if (cnt_q == GAP_LAST) begin
            state_n  = S_D0;
            cnt_n    = '0;
            boundary = 1'b1;
         end
         default: begin
            state_n = S_D0;
            cnt_n   = '0;
         end
      endcase
   end

   // A load coinciding with the boundary wins over the pending copy.
   always_comb begin
      act_l1_n = act_l1_q;
      act_l0_n = act_l0_q;
      if (boundary) begin
         if (bus.load) begin
            act_l1_n = bus.l1;
            act_l0_n = bus.l0;
         end else if (pend_q) begin
            act_l1_n = pend_l1_q;
            act_l0_n = pend_l0_q;
         end
      end
   end

   assign digit = (state_n == S_D1) ? act_l1_n : act_l0_n;

   seg7_decode u_decode (
      .digit (digit),
      .seg   (dec_seg)
   );

   always_comb begin
      seg_n = SEG_BLANK;
      an_n  = 2'b00;
      case (state_n)
         S_D0: begin
            seg_n = dec_seg;
            an_n  = 2'b01;
         end
         S_D1: if (!((BLANK_LEADING != 0) && (act_l1_n == 4'd0))) begin
            seg_n = dec_seg;
            an_n  = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_D0;
         cnt_q     <= '0;
         act_l1_q  <= 4'd0;
         act_l0_q  <= 4'd0;
         pend_l1_q <= 4'd0;
         pend_l0_q <= 4'd0;
         pend_q    <= 1'b0;
         seg_q     <= SEG_OFF;
         an_q      <= AN_OFF;
         tick_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         act_l1_q <= act_l1_n;
         act_l0_q <= act_l0_n;
         if (boundary) begin
            pend_q <= 1'b0;
         end else if (bus.load) begin
            pend_l1_q <= bus.l1;
            pend_l0_q <= bus.l0;
            pend_q    <= 1'b1;
         end
         seg_q  <= (ACTIVE_LOW != 0) ? ~seg_n : seg_n;
         an_q   <= (ACTIVE_LOW != 0) ? ~an_n  : an_n;
         tick_q <= boundary;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver at REFRESH_DIV=8, GAP_CYC=2, active-high pins.
module tb_seg7_mux_driver;
   import seg7_pkg::*;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [6:0] exp_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   seg7_mux_driver_if bus ();

   seg7_mux_driver #(
      .REFRESH_DIV   (8),
      .GAP_CYC       (2),
      .ACTIVE_LOW    (0),
      .BLANK_LEADING (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] digits);
      bus.load = ld;
      bus.l1   = digits[7:4];
      bus.l0   = digits[3:0];
   endtask

   // Position 0 is the first units cycle of a frame.
   task automatic check_cycle(input int i, input logic [6:0] useg, input logic [6:0] tseg,
                              input logic [1:0] tan, input string tag);
      logic [6:0] es;
      logic [1:0] ea;
      if (i < 8)       begin es = useg;  ea = 2'b01; end
      else if (i < 10) begin es = 7'h00; ea = 2'b00; end
      else if (i < 18) begin es = tseg;  ea = tan;   end
      else             begin es = 7'h00; ea = 2'b00; end
      chk($sformatf("%s[%0d].seg", tag, i), 32'(bus.seg), 32'(es));
      chk($sformatf("%s[%0d].an", tag, i), 32'(bus.an), 32'(ea));
      chk($sformatf("%s[%0d].tick", tag, i), 32'(bus.frame_tick), 32'(i == 0));
   endtask

   task automatic check_frame(input logic [6:0] useg, input logic [6:0] tseg,
                              input logic [1:0] tan, input string tag,
                              input int pa, input logic [7:0] da,
                              input int pb, input logic [7:0] db);
      for (int i = 0; i < 20; i++) begin
         check_cycle(i, useg, tseg, tan, tag);
         if (i == pa)      drive(1'b1, da);
         else if (i == pb) drive(1'b1, db);
         else              bus.load = 1'b0;
         tick();
      end
      bus.load = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n = 0;
      do begin
         tick();
         bus.load = 1'b0;
         n++;
      end while (!bus.frame_tick && n < 100);
      chk({tag, ".frame_wait"}, 32'(bus.frame_tick), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00);
      repeat (3) tick();
      chk("rst.seg", 32'(bus.seg), 32'h00);
      chk("rst.an", 32'(bus.an), 32'h0);
      chk("rst.tick", 32'(bus.frame_tick), 32'h0);
      chk("rst.pend", 32'(dut.pend_q), 32'h0);

      // 1: basic 42 frame
      rst_n = 1'b1;
      drive(1'b1, 8'h42);
      wait_frame("t1");
      check_frame(7'h5B, 7'h66, 2'b10, "t1", -1, 8'h00, -1, 8'h00);

      // 2: leading zero blanked, period unchanged
      drive(1'b1, 8'h07);
      wait_frame("t2");
      check_frame(7'h07, 7'h00, 2'b00, "t2", -1, 8'h00, -1, 8'h00);

      // 3: invalid BCD gives dashes, then every digit in both slots
      drive(1'b1, 8'hAC);
      wait_frame("t3");
      check_frame(7'h40, 7'h40, 2'b10, "t3dash", -1, 8'h00, -1, 8'h00);
      for (int d = 0; d < 10; d++) begin
         drive(1'b1, {4'(d), 4'(d)});
         wait_frame("t3dig");
         check_frame(exp_tab[d], (d == 0) ? 7'h00 : exp_tab[d], (d == 0) ? 2'b00 : 2'b10,
                     $sformatf("t3d%0d", d), -1, 8'h00, -1, 8'h00);
      end

      // 4: two loads inside a 99 frame; only the last one shows next frame
      drive(1'b1, 8'h99);
      wait_frame("t4");
      check_frame(7'h6F, 7'h6F, 2'b10, "t4hold", 5, 8'h12, 15, 8'h34);
      // 5: load on the boundary edge bypasses the pending register
      check_frame(7'h66, 7'h4F, 2'b10, "t4_34", 19, 8'h56, -1, 8'h00);
      chk("t5.pend", 32'(dut.pend_q), 32'h0);
      check_frame(7'h7D, 7'h6D, 2'b10, "t5_56", -1, 8'h00, -1, 8'h00);

      // 6: asynchronous reset in the middle of the tens slot
      repeat (12) tick();
      chk("t6.pre_an", 32'(bus.an), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.async_seg", 32'(bus.seg), 32'h00);
      chk("t6.async_an", 32'(bus.an), 32'h0);
      chk("t6.async_tick", 32'(bus.frame_tick), 32'h0);
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      for (int i = 1; i < 20; i++) begin
         check_cycle(i, 7'h3F, 7'h00, 2'b00, "t6");
         tick();
      end
      chk("t6.first_boundary", 32'(bus.frame_tick), 32'h1);
      chk("t6.first_seg", 32'(bus.seg), 32'h3F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
